// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encodings and line record for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int LINES      = 8;
  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int OFFSET_W   = 4;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;
  localparam int BLK_W      = TAG_W + INDEX_W;
  localparam int WSEL_W     = 2;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] sel);
    return line[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] sel,
                                                 input logic [31:0] w);
    logic [LINE_W-1:0] r;
    r = line;
    r[{sel, 5'b0} +: 32] = w;
    return r;
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// CPU-side word port and memory-side block port of the data cache.
interface data_cache_if;
  import dcache_pkg::*;
  logic              read;
  logic              write;
  logic [31:0]       address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              busywait;
  logic              mem_read;
  logic              mem_write;
  logic [BLK_W-1:0]  mem_address;
  logic [LINE_W-1:0] mem_writedata;
  logic [LINE_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays: one synchronous write port, one combinational read port.
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [INDEX_W-1:0] widx,
  input  line_t              wline,
  input  logic [INDEX_W-1:0] ridx,
  output line_t              rline
);
  logic [LINES-1:0]             valid;
  logic [LINES-1:0]             dirty;
  logic [LINES-1:0][TAG_W-1:0]  tags;
  logic [LINES-1:0][LINE_W-1:0] data;

  // Only the state bits are reset; tags and data keep stale contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[widx] <= wline.valid;
      dirty[widx] <= wline.dirty;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      tags[widx] <= wline.tag;
      data[widx] <= wline.data;
    end
  end

  assign rline.valid = valid[ridx];
  assign rline.dirty = dirty[ridx];
  assign rline.tag   = tags[ridx];
  assign rline.data  = data[ridx];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with IDLE/WRITEBACK/FETCH/UPDATE miss FSM.
module data_cache
  import dcache_pkg::*;
(
  input logic         clock,
  input logic         reset,
  data_cache_if.slave bus
);
  logic [1:0]         state, state_nxt;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx, rd_idx, wr_idx;
  logic [WSEL_W-1:0]  req_word;
  logic [BLK_W-1:0]   miss_blk;
  line_t              rline, wline;
  logic               we, req, idle, hit, miss;
  logic               unused_addr_bits;

  assign req_tag  = bus.address[31:7];
  assign req_idx  = bus.address[6:4];
  assign req_word = bus.address[3:2];
  assign unused_addr_bits = ^bus.address[1:0];

  // While reset is low the outputs behave as in IDLE, whatever the stored state.
  assign idle   = (state == IDLE) || !reset;
  assign req    = bus.read ^ bus.write;
  assign rd_idx = idle ? req_idx : miss_blk[INDEX_W-1:0];
  assign hit    = idle && rline.valid && (rline.tag == req_tag);
  assign miss   = idle && req && !hit;

  assign bus.busywait      = !idle || miss;
  assign bus.readdata      = get_word(rline.data, req_word);
  assign bus.mem_read      = reset && (state == FETCH);
  assign bus.mem_write     = reset && (state == WRITEBACK);
  assign bus.mem_address   = (state == WRITEBACK) ? {rline.tag, miss_blk[INDEX_W-1:0]} : miss_blk;
  assign bus.mem_writedata = rline.data;

  dcache_line_store u_store (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .widx  (wr_idx),
    .wline (wline),
    .ridx  (rd_idx),
    .rline (rline)
  );

  always_comb begin
    we     = 1'b0;
    wr_idx = req_idx;
    wline  = rline;
    if (reset) begin
      if (state == UPDATE) begin
        we     = 1'b1;
        wr_idx = miss_blk[INDEX_W-1:0];
        wline  = '{valid: 1'b1, dirty: 1'b0, tag: miss_blk[BLK_W-1:INDEX_W], data: bus.mem_readdata};
      end else if (state == IDLE && hit && bus.write && !bus.read) begin
        we          = 1'b1;
        wline.dirty = 1'b1;
        wline.data  = put_word(rline.data, req_word, bus.writedata);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss) state_nxt = (rline.valid && rline.dirty) ? WRITEBACK : FETCH;
      WRITEBACK: if (!bus.mem_busywait) state_nxt = FETCH;
      FETCH:     if (!bus.mem_busywait) state_nxt = UPDATE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the missing block so a dropped request cannot redirect the fill.
  always_ff @(posedge clock) begin
    if (reset && state == IDLE && miss) miss_blk <= {req_tag, req_idx};
  end
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench: driver queues expected CPU responses and memory transfers, monitors pop and compare.
`timescale 1ns/1ps
module tb_data_cache;
  import dcache_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  data_cache_if bus();
  data_cache dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct { bit rd; logic [31:0] addr; logic [31:0] data; int stall; } cpu_exp_t;
  typedef struct { bit wr; logic [27:0] addr; logic [127:0] data; } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  cpu_exp_t ce;
  mem_exp_t me;
  int checks = 0;
  int errors = 0;
  int stall  = 0;

  function automatic logic [127:0] blk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'hA000_0000 | 32'(b*16 + w*4);
    return r;
  endfunction

  // Memory: 16 blocks, busy for 16 cycles per transfer with the last cycle not busy.
  logic [127:0] mem [16];
  bit           mem_init;
  int unsigned  mcnt;
  always_comb bus.mem_readdata = mem[bus.mem_address[3:0]];
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mcnt != 15);

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int b = 0; b < 16; b++) mem[b] <= blk(b);
      mem_init <= 1'b1;
      mcnt     <= 0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (mcnt == 15) begin
        mcnt <= 0;
        if (bus.mem_write) mem[bus.mem_address[3:0]] <= bus.mem_writedata;
      end else mcnt <= mcnt + 1;
    end else mcnt <= 0;
  end

  // Memory-side monitor
  always @(negedge clock) begin
    if (bus.mem_read && bus.mem_write) begin
      checks++; errors++;
      $display("FAIL mem_excl: mem_read and mem_write both high");
    end
    if ((bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_xfer: unexpected wr=%0b addr=%h", bus.mem_write, bus.mem_address);
      end else begin
        me = mem_q.pop_front();
        if (me.wr != bus.mem_write || me.addr != bus.mem_address ||
            (me.wr && me.data != bus.mem_writedata)) begin
          errors++;
          $display("FAIL mem_xfer: got wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                   bus.mem_write, bus.mem_address, bus.mem_writedata, me.wr, me.addr, me.data);
        end
      end
    end
  end

  // CPU-side monitor: counts stall cycles, compares on the completing cycle
  always @(negedge clock) begin
    if (!reset || !(bus.read ^ bus.write)) stall = 0;
    else if (bus.busywait) stall++;
    else begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_rsp: unexpected completion addr=%h", bus.address);
      end else begin
        ce = cpu_q.pop_front();
        if (ce.stall != stall || (ce.rd && bus.readdata != ce.data)) begin
          errors++;
          $display("FAIL cpu_rsp addr=%h: got data=%h stall=%0d expected data=%h stall=%0d",
                   ce.addr, bus.readdata, stall, ce.data, ce.stall);
        end
      end
      stall = 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input bit wr, input logic [27:0] a, input logic [127:0] d);
    mem_q.push_back('{wr, a, d});
  endtask

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_stall);
    bit done;
    cpu_q.push_back('{rd, a, exp_rd, exp_stall});
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (!bus.busywait) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h: busywait still high", a);
    end
    @(posedge clock); #1;
    bus.read = 0; bus.write = 0;
  endtask

  initial begin
    logic [127:0] wb;
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busywait", bus.busywait, 0);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1;

    exp_mem(0, 28'h4, '0);
    access(1, 0, 32'h40, 0, 32'hA000_0040, 18);
    access(0, 1, 32'h44, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 32'h44, 0, 32'hDEAD_BEEF, 0);
    access(1, 0, 32'h4C, 0, 32'hA000_004C, 0);

    wb = blk(4); wb[63:32] = 32'hDEAD_BEEF;
    exp_mem(1, 28'h4, wb);
    exp_mem(0, 28'hC, '0);
    access(1, 0, 32'hC0, 0, 32'hA000_00C0, 34);

    // read and write together are ignored
    bus.read = 1; bus.write = 1; bus.address = 32'h40; bus.writedata = 32'h1111_1111;
    repeat (3) begin
      @(negedge clock);
      check("both_busywait", bus.busywait, 0);
      check("both_mem_read", bus.mem_read, 0);
      check("both_mem_write", bus.mem_write, 0);
    end
    @(posedge clock); #1 bus.read = 0; bus.write = 0;
    access(1, 0, 32'hC4, 0, 32'hA000_00C4, 0);

    exp_mem(0, 28'h2, '0);
    access(0, 1, 32'h28, 32'h0BAD_F00D, 0, 18);
    access(1, 0, 32'h28, 0, 32'h0BAD_F00D, 0);

    // reset in the middle of a fetch
    bus.read = 1; bus.address = 32'h40;
    @(negedge clock);
    check("miss_busywait", bus.busywait, 1);
    check("miss_idle_mem_read", bus.mem_read, 0);
    @(negedge clock);
    check("fetch_mem_read", bus.mem_read, 1);
    check("fetch_mem_addr", bus.mem_address, 28'h4);
    repeat (2) @(negedge clock);
    @(posedge clock); #1 reset = 0; bus.read = 0;
    @(negedge clock);
    check("inrst_mem_read", bus.mem_read, 0);
    check("inrst_busywait", bus.busywait, 0);
    @(posedge clock); #1 reset = 1;
    @(negedge clock);
    check("postrst_mem_read", bus.mem_read, 0);
    check("postrst_mem_write", bus.mem_write, 0);
    check("postrst_busywait", bus.busywait, 0);
    @(posedge clock); #1;

    exp_mem(0, 28'hA, '0);
    access(1, 0, 32'hA8, 0, 32'hA000_00A8, 18);
    exp_mem(0, 28'h2, '0);
    access(1, 0, 32'h28, 0, 32'hA000_0028, 18);
    exp_mem(0, 28'h4, '0);
    access(1, 0, 32'h44, 0, 32'hDEAD_BEEF, 18);
    exp_mem(0, 28'hF, '0);
    access(0, 1, 32'hFF, 32'h55AA_55AA, 0, 18);
    access(1, 0, 32'hFC, 0, 32'h55AA_55AA, 0);

    repeat (3) @(posedge clock);
    check("cpu_q_empty", 128'(cpu_q.size()), 0);
    check("mem_q_empty", 128'(mem_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port: clock  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  synchronous active-low reset, sampled on rising clock.
REQ-004 Port: read  in  1  CPU word-read request, held until busywait low.
REQ-005 Port: write  in  1  CPU word-write request, held until busywait low.
REQ-006 Port: address  in  32  CPU byte address; tag [31:7], index [6:4], word [3:2], [1:0] ignored.
REQ-007 Port: writedata  in  32  CPU store word.
REQ-008 Port: readdata  out  32  CPU load word.
REQ-009 Port: busywait  out  1  CPU stall.
REQ-010 Port: mem_read  out  1  block-read request to data memory.
REQ-011 Port: mem_write  out  1  block-write request to data memory.
REQ-012 Port: mem_address  out  28  block address {tag,index} to memory.
REQ-013 Port: mem_writedata  out  128  victim block, byte 0 at [7:0].
REQ-014 Port: mem_readdata  in  128  fetched block, byte 0 at [7:0].
REQ-015 Port: mem_busywait  in  1  memory stall; low marks the final transfer cycle.

Function
REQ-016 Organisation SHALL be direct-mapped, 8 lines x 16 bytes, write-back, write-allocate; per line: valid, dirty, 25-bit tag, 128-bit data.
REQ-017 FSM states SHALL be IDLE, WRITEBACK, FETCH, UPDATE.
REQ-018 Hit SHALL be combinational: valid[index] and tag match, in IDLE only.
REQ-019 Read hit: readdata = selected word same cycle, busywait 0, zero added latency.
REQ-020 Write hit: busywait 0; word written and dirty set on the next rising edge.
REQ-021 Miss (read xor write, no hit) SHALL assert busywait combinationally in the request cycle.
REQ-022 IDLE -> WRITEBACK on miss with dirty victim; IDLE -> FETCH on miss with clean or invalid victim.
REQ-023 WRITEBACK: mem_write=1, mem_address={stored tag,index}, mem_writedata=line; -> FETCH on edge with mem_busywait=0.
REQ-024 FETCH: mem_read=1, mem_address=address[31:4]; -> UPDATE on edge with mem_busywait=0.
REQ-025 UPDATE: mem_read=mem_write=0; on the edge, line <= mem_readdata, tag written, valid=1, dirty=0; -> IDLE.
REQ-026 After UPDATE the held request SHALL re-evaluate in IDLE as a hit; write-miss data merges per REQ-020.
REQ-027 mem_read and mem_write SHALL never be high together and SHALL be 0 in IDLE.
REQ-028 busywait SHALL be 1 in every non-IDLE state.
REQ-029 read and write both high SHALL be ignored: no access, busywait 0, no state change.
REQ-030 Miss latency with memory busy for 16 cycles: clean miss 18 cycles, dirty miss 34 cycles to busywait low.
REQ-031 Request dropped mid-miss SHALL NOT abort the sequence; the line fill completes.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE and clear all valid and dirty bits; tags and data are not cleared.
REQ-033 During and after reset: mem_read=0, mem_write=0, busywait follows REQ-021; reset overrides any mid-miss state.

Structure
REQ-034 Shared package dcache_pkg SHALL hold line count, line bytes, tag/index/offset widths, and FSM state encodings.
REQ-035 Sub-module dcache_line_store SHALL hold the valid/dirty/tag/data arrays with one synchronous write port and combinational read.

Verification
REQ-036 After reset, read 0x0000_0040 -> busywait high, FETCH mem_address 0x0000004, 18-cycle stall, readdata = memory word at 0x40.
REQ-037 Write 0xDEADBEEF to 0x44, then read 0x44 -> zero-stall hit returns 0xDEADBEEF; line 4 dirty.
REQ-038 Read 0x0000_00C0 (same index 4, new tag) -> WRITEBACK mem_address 0x0000004 with 0xDEADBEEF at bytes 4-7, then FETCH 0x000000C; 34-cycle stall.
REQ-039 reset low during FETCH -> next edge IDLE, mem_read 0; re-read 0x40 misses.
REQ-040 read=write=1 at 0x40 -> busywait 0, mem_read and mem_write stay 0, no state change.
